// File: rtl/tick_sched_pkg.sv
// Shared types for the tick event scheduler: FSM state encoding and channel index sizing.
package tick_sched_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_e;

    localparam int DEF_NUM_CH = 8;

    // Channel index width; keeps at least one bit so a 1-channel build still elaborates.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_CH_W = ch_width(DEF_NUM_CH);

    typedef logic [DEF_CH_W-1:0] ch_idx_t;

endpackage

// File: rtl/tick_event_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH = 8,
    localparam int CH_W = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   grant,
    output logic              any
);

    always_comb begin
        int c;
        c     = 0;
        grant = '0;
        any   = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (int'(ptr) + k) % NUM_CH;
            if (!any && req[c]) begin
                grant = CH_W'(c);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tick_event_scheduler.sv
// Multi-channel tick scheduler: scans channel counters on each tick and serves expiries
// through a single valid/ready slot. Define TICK_SCHED_OVERRUN_EN for sticky overrun flags.
module tick_event_scheduler
    import tick_sched_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int PERIOD_W = 16,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic                clk_100mhz,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_en,
    output logic                ev_valid,
    output logic [CH_W-1:0]     ev_ch,
    input  logic                ev_ready,
    output logic                busy
`ifdef TICK_SCHED_OVERRUN_EN
    ,
    output logic [NUM_CH-1:0]   overrun
`endif
);

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     idx_q, idx_d;
    logic                defer_q, defer_d;
    logic [PERIOD_W-1:0] period_q [NUM_CH];
    logic [PERIOD_W-1:0] period_d [NUM_CH];
    logic [PERIOD_W-1:0] count_q  [NUM_CH];
    logic [PERIOD_W-1:0] count_d  [NUM_CH];
    logic [NUM_CH-1:0]   en_q, en_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [NUM_CH-1:0]   set_vec, clr_vec;
    logic                ev_valid_q, ev_valid_d;
    logic [CH_W-1:0]     ev_ch_q, ev_ch_d;
    logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0]     grant;
    logic                any_req;
    logic                cfg_hit;
`ifdef TICK_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0]   overrun_q, overrun_d;
`endif

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req   (pending_q),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .any   (any_req)
    );

    assign cfg_hit = cfg_we && (int'(cfg_ch) < NUM_CH);

    // Scan sequencer; a tick during SCAN is remembered once and replayed as an immediate rescan.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        defer_d = defer_q;
        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                end
            end
            S_SCAN: begin
                if (idx_q == LAST_CH) begin
                    if (defer_q || tick) begin
                        idx_d   = '0;
                        defer_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    idx_d = idx_q + CH_W'(1);
                    if (tick) defer_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                defer_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        period_d   = period_q;
        count_d    = count_q;
        en_d       = en_q;
        set_vec    = '0;
        clr_vec    = '0;
        ev_valid_d = ev_valid_q;
        ev_ch_d    = ev_ch_q;
        rr_ptr_d   = rr_ptr_q;

        if (state_q == S_SCAN && en_q[idx_q] && period_q[idx_q] != '0) begin
            if (count_q[idx_q] <= PERIOD_W'(1)) begin
                count_d[idx_q] = period_q[idx_q];
                set_vec[idx_q] = 1'b1;
            end else begin
                count_d[idx_q] = count_q[idx_q] - PERIOD_W'(1);
            end
        end

        // Slot refills on the same edge it drains, giving one event per cycle.
        if (!ev_valid_q || ev_ready) begin
            ev_valid_d = any_req;
            if (any_req) begin
                ev_ch_d        = grant;
                clr_vec[grant] = 1'b1;
                rr_ptr_d       = (grant == LAST_CH) ? '0 : grant + CH_W'(1);
            end
        end

        pending_d = (pending_q & ~clr_vec) | set_vec;

        // Configuration overrides whatever the scan did to this channel this cycle.
        if (cfg_hit) begin
            period_d[cfg_ch]  = cfg_period;
            count_d[cfg_ch]   = cfg_period;
            en_d[cfg_ch]      = cfg_en;
            pending_d[cfg_ch] = 1'b0;
        end
    end

`ifdef TICK_SCHED_OVERRUN_EN
    always_comb begin
        overrun_d = overrun_q | (set_vec & pending_q);
        if (cfg_hit) overrun_d[cfg_ch] = 1'b0;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) overrun_q <= '0;
        else        overrun_q <= overrun_d;
    end

    assign overrun = overrun_q;
`endif

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            defer_q    <= 1'b0;
            en_q       <= '0;
            pending_q  <= '0;
            ev_valid_q <= 1'b0;
            ev_ch_q    <= '0;
            rr_ptr_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            defer_q    <= defer_d;
            en_q       <= en_d;
            pending_q  <= pending_d;
            ev_valid_q <= ev_valid_d;
            ev_ch_q    <= ev_ch_d;
            rr_ptr_q   <= rr_ptr_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i] <= period_d[i];
                count_q[i]  <= count_d[i];
            end
        end
    end

    assign ev_valid = ev_valid_q;
    assign ev_ch    = ev_ch_q;
    assign busy     = (state_q == S_SCAN);

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Directed bench for tick_event_scheduler: table of single-channel period cases plus
// hand-written sequences for latency, arbitration, deferred ticks, collisions and reset.
module tb_tick_event_scheduler;

    localparam int NUM_CH   = 8;
    localparam int PERIOD_W = 16;
    localparam int CH_W     = $clog2(NUM_CH);
    localparam int SETTLE   = 2 * NUM_CH + 4;

    logic                clk_100mhz = 1'b0;
    logic                rst_n      = 1'b0;
    logic                tick       = 1'b0;
    logic                cfg_we     = 1'b0;
    logic [CH_W-1:0]     cfg_ch     = '0;
    logic [PERIOD_W-1:0] cfg_period = '0;
    logic                cfg_en     = 1'b0;
    logic                ev_ready   = 1'b0;
    logic                ev_valid;
    logic [CH_W-1:0]     ev_ch;
    logic                busy;
`ifdef TICK_SCHED_OVERRUN_EN
    logic [NUM_CH-1:0]   overrun;
`endif

    tick_event_scheduler #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk_100mhz (clk_100mhz),
        .rst_n      (rst_n),
        .tick       (tick),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_en     (cfg_en),
        .ev_valid   (ev_valid),
        .ev_ch      (ev_ch),
        .ev_ready   (ev_ready),
        .busy       (busy)
`ifdef TICK_SCHED_OVERRUN_EN
        ,
        .overrun    (overrun)
`endif
    );

    always #5 clk_100mhz = ~clk_100mhz;

    int total = 0;
    int bad   = 0;

    int ev_cnt [NUM_CH];
    int ev_total = 0;
    int grant_log [$];

    initial for (int i = 0; i < NUM_CH; i++) ev_cnt[i] = 0;

    // A transfer is recorded in the cycle it completes (valid and ready both high).
    always @(negedge clk_100mhz) begin
        if (rst_n && ev_valid && ev_ready) begin
            ev_cnt[ev_ch] = ev_cnt[ev_ch] + 1;
            ev_total      = ev_total + 1;
            grant_log.push_back(int'(ev_ch));
        end
    end

    typedef struct {
        int ch;
        int per;
        int en;
        int ticks;
        int exp_ev;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_100mhz);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tick     = 1'b0;
        cfg_we   = 1'b0;
        ev_ready = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic cfg(input int ch, input int per, input int en);
        logic [31:0] c32;
        logic [31:0] p32;
        c32        = ch;
        p32        = per;
        cfg_we     = 1'b1;
        cfg_ch     = c32[CH_W-1:0];
        cfg_period = p32[PERIOD_W-1:0];
        cfg_en     = (en != 0);
        step(1);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic tick_wait(input int n);
        repeat (n) begin
            pulse_tick();
            step(SETTLE);
        end
    endtask

    initial begin
        int base_tot;
        int base_ch;
        int base_log;
        int nbusy;

        vecs[0] = '{ch: 0, per: 3, en: 1, ticks: 9,  exp_ev: 3};
        vecs[1] = '{ch: 7, per: 1, en: 1, ticks: 5,  exp_ev: 5};
        vecs[2] = '{ch: 2, per: 4, en: 1, ticks: 10, exp_ev: 2};
        vecs[3] = '{ch: 5, per: 2, en: 1, ticks: 7,  exp_ev: 3};
        vecs[4] = '{ch: 4, per: 0, en: 1, ticks: 20, exp_ev: 0};
        vecs[5] = '{ch: 6, per: 5, en: 0, ticks: 20, exp_ev: 0};
        vecs[6] = '{ch: 3, per: 1, en: 0, ticks: 20, exp_ev: 0};

        do_reset();
        check("reset_ev_valid", ev_valid, 0);
        check("reset_ev_ch", ev_ch, 0);
        check("reset_busy", busy, 0);
`ifdef TICK_SCHED_OVERRUN_EN
        check("reset_overrun", overrun, 0);
`endif

        // Single-channel period table
        for (int v = 0; v < 7; v++) begin
            do_reset();
            cfg(vecs[v].ch, vecs[v].per, vecs[v].en);
            ev_ready = 1'b1;
            base_tot = ev_total;
            base_ch  = ev_cnt[vecs[v].ch];
            tick_wait(vecs[v].ticks);
            check($sformatf("vec%0d_ch_events", v), ev_cnt[vecs[v].ch] - base_ch, vecs[v].exp_ev);
            check($sformatf("vec%0d_all_events", v), ev_total - base_tot, vecs[v].exp_ev);
        end

        // First-event latency and busy window on the third tick of a period-3 channel
        do_reset();
        cfg(0, 3, 1);
        ev_ready = 1'b1;
        tick_wait(2);
        pulse_tick();
        check("lat_busy_t1", busy, 1);
        check("lat_valid_t1", ev_valid, 0);
        step(1);
        check("lat_valid_t2", ev_valid, 0);
        step(1);
        check("lat_valid_t3", ev_valid, 1);
        check("lat_ch_t3", ev_ch, 0);
        step(NUM_CH - 3);
        check("busy_last_scan_cycle", busy, 1);
        step(1);
        check("busy_drop", busy, 0);

        // Stalled consumer: arbitration order and stable ev_ch
        do_reset();
        cfg(1, 1, 1);
        cfg(2, 1, 1);
        cfg(5, 1, 1);
        ev_ready = 1'b0;
        tick_wait(2);
        check("stall_valid", ev_valid, 1);
        check("stall_ch", ev_ch, 1);
        step(3);
        check("stall_ch_stable", ev_ch, 1);
`ifdef TICK_SCHED_OVERRUN_EN
        check("stall_overrun", overrun, 8'h24);
`endif
        base_log = grant_log.size();
        ev_ready = 1'b1;
        step(8);
        check("rr_count", grant_log.size() - base_log, 4);
        if (grant_log.size() - base_log >= 4) begin
            check("rr_grant0", grant_log[base_log + 0], 1);
            check("rr_grant1", grant_log[base_log + 1], 2);
            check("rr_grant2", grant_log[base_log + 2], 5);
            check("rr_grant3", grant_log[base_log + 3], 1);
        end
        check("rr_drained", ev_valid, 0);

        // Ticks during SCAN: one deferred rescan, the third tick dropped
        do_reset();
        cfg(0, 1, 1);
        ev_ready = 1'b1;
        base_ch  = ev_cnt[0];
        nbusy    = 0;
        tick     = 1'b1;
        step(1);
        for (int c = 1; c <= 3 * NUM_CH; c++) begin
            tick = (c == 2 || c == 4);
            if (busy) nbusy++;
            step(1);
        end
        tick = 1'b0;
        check("defer_busy_cycles", nbusy, 2 * NUM_CH);
        step(4);
        check("defer_events", ev_cnt[0] - base_ch, 2);
        check("defer_idle", busy, 0);

        // Config write colliding with the scan of the same channel at count=1
        do_reset();
        cfg(3, 2, 1);
        ev_ready = 1'b1;
        tick_wait(1);
        base_ch = ev_cnt[3];
        pulse_tick();
        step(3);
        cfg(3, 5, 1);
        step(SETTLE);
        check("collide_no_event", ev_cnt[3] - base_ch, 0);
        tick_wait(4);
        check("collide_reload_4", ev_cnt[3] - base_ch, 0);
        tick_wait(1);
        check("collide_reload_5", ev_cnt[3] - base_ch, 1);

        // Asynchronous reset with an event in the slot and another pending
        do_reset();
        cfg(1, 1, 1);
        cfg(2, 1, 1);
        ev_ready = 1'b0;
        pulse_tick();
        step(3);
        check("prerst_valid", ev_valid, 1);
        check("prerst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", ev_valid, 0);
        check("async_rst_busy", busy, 0);
        @(posedge clk_100mhz);
        #1;
        step(1);
        rst_n    = 1'b1;
        ev_ready = 1'b1;
        base_tot = ev_total;
        tick_wait(3);
        check("postrst_no_events", ev_total - base_tot, 0);
        check("postrst_valid", ev_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
